// File: rtl/audrey_mix_pkg.sv
// Shared sizing, FSM encodings and saturation helper for the audrey mixer slice.
package audrey_mix_pkg;

  localparam int NUM_VOICES  = 4;
  localparam int SAMPLE_W    = 16;
  localparam int VOL_W       = 8;
  localparam int PAN_W       = 4;
  localparam int PAN_MAX     = 8;
  localparam int ACC_W       = 30;
  localparam int COEF_W      = 12;
  localparam int MIX_SHIFT   = 11;
  localparam int MIX_W       = ACC_W - MIX_SHIFT;
  localparam int MIX_LATENCY = 10;
  localparam int VIDX_W      = $clog2(NUM_VOICES);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_MST  = 2'd2;
  localparam state_t ST_OUT  = 2'd3;

  // Returns {clipped, saturated_sample}.
  function automatic logic [SAMPLE_W:0] sat_sample(input logic signed [MIX_W:0] x);
    logic signed [MIX_W:0] hi, lo;
    hi = (MIX_W+1)'(32767);
    lo = -(MIX_W+1)'(32768);
    if (x > hi)      sat_sample = {1'b1, 16'sh7fff};
    else if (x < lo) sat_sample = {1'b1, 16'sh8000};
    else             sat_sample = {1'b0, x[SAMPLE_W-1:0]};
  endfunction

endpackage

// File: rtl/mix_mac.sv
// Shared 16x12 signed multiplier feeding the left/right 30-bit accumulators.
module mix_mac
  import audrey_mix_pkg::*;
(
  input  logic                       clk_audio,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       sel_right,
  input  logic signed [SAMPLE_W-1:0] samp,
  input  logic [COEF_W-1:0]          coef,
  output logic signed [ACC_W-1:0]    acc_l,
  output logic signed [ACC_W-1:0]    acc_r
);

  // coef never exceeds 255*8, so its top bit is always 0 and it reads as a positive signed value.
  logic signed [SAMPLE_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]           prod_ext;

  assign prod     = samp * $signed(coef);
  assign prod_ext = {{(ACC_W-SAMPLE_W-COEF_W){prod[SAMPLE_W+COEF_W-1]}}, prod};

  always_ff @(posedge clk_audio) begin
    if (!rst_n || clr) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (en) begin
      if (sel_right) acc_r <= acc_r + prod_ext;
      else           acc_l <= acc_l + prod_ext;
    end
  end

endmodule

// File: rtl/audrey_mixer.sv
// Four-voice stereo mixer: snapshot on strobe, 8-step shared MAC, master gain, saturate.
module audrey_mixer
  import audrey_mix_pkg::*;
(
  input  logic                                clk_audio,
  input  logic                                rst_n,
  input  logic                                sample_strobe,
  input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES-1:0][VOL_W-1:0]    voice_vol,
  input  logic [NUM_VOICES-1:0][PAN_W-1:0]    voice_pan,
  input  logic [NUM_VOICES-1:0]               voice_mute,
  input  logic [VOL_W-1:0]                    master_vol,
  input  logic                                clip_clr,
  output logic [SAMPLE_W-1:0]                 left_out,
  output logic [SAMPLE_W-1:0]                 right_out,
  output logic                                out_valid,
  output logic                                busy,
  output logic                                clip_flag,
  output logic                                overrun_flag
);

  state_t state;
  logic [2:0] step;

  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] s_in;
  logic [NUM_VOICES-1:0][VOL_W-1:0]    s_vol;
  logic [NUM_VOICES-1:0][PAN_W-1:0]    s_pan, pan_c;
  logic [NUM_VOICES-1:0]               s_mute;
  logic [VOL_W-1:0]                    s_master;

  assign busy = (state != ST_IDLE);

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_pan
    assign pan_c[i] = (voice_pan[i] > PAN_W'(PAN_MAX)) ? PAN_W'(PAN_MAX) : voice_pan[i];
  end

  always_ff @(posedge clk_audio) begin
    if (state == ST_IDLE && sample_strobe) begin
      s_in     <= voice_in;
      s_vol    <= voice_vol;
      s_pan    <= pan_c;
      s_mute   <= voice_mute;
      s_master <= master_vol;
    end
  end

  // Step k: voice k/2, odd steps feed the right channel.
  logic [VIDX_W-1:0]          v;
  logic                       right;
  logic [PAN_W-1:0]           g;
  logic [COEF_W-1:0]          coef;
  logic signed [SAMPLE_W-1:0] samp;

  assign v     = step[2:1];
  assign right = step[0];
  assign g     = right ? s_pan[v] : PAN_W'(PAN_MAX) - s_pan[v];
  assign coef  = COEF_W'(s_vol[v]) * COEF_W'(g);
  assign samp  = s_mute[v] ? '0 : $signed(s_in[v]);

  logic signed [ACC_W-1:0] acc_l, acc_r;

  mix_mac u_mac (
    .clk_audio (clk_audio),
    .rst_n     (rst_n),
    .clr       (state == ST_IDLE && sample_strobe),
    .en        (state == ST_ACC),
    .sel_right (right),
    .samp      (samp),
    .coef      (coef),
    .acc_l     (acc_l),
    .acc_r     (acc_r)
  );

  // Master stage: step[0]=0 handles left, step[0]=1 handles right.
  logic signed [ACC_W-1:0]         acc_sel;
  logic signed [MIX_W-1:0]         mix;
  logic signed [MIX_W+VOL_W:0]     mprod;
  logic signed [MIX_W:0]           scaled;
  logic [SAMPLE_W:0]               sat;
  logic [SAMPLE_W-1:0]             l_hold;

  assign acc_sel = step[0] ? acc_r : acc_l;
  assign mix     = MIX_W'(acc_sel >>> MIX_SHIFT);
  assign mprod   = mix * $signed({1'b0, s_master});
  assign scaled  = (MIX_W+1)'(mprod >>> VOL_W);
  assign sat     = sat_sample(scaled);

  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step      <= '0;
      left_out  <= '0;
      right_out <= '0;
      l_hold    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: if (sample_strobe) begin
          state <= ST_ACC;
          step  <= '0;
        end
        ST_ACC: begin
          step <= step + 3'd1;
          if (step == 3'd7) begin
            state <= ST_MST;
            step  <= '0;
          end
        end
        ST_MST: if (!step[0]) begin
          l_hold <= sat[SAMPLE_W-1:0];
          step   <= 3'd1;
        end else begin
          left_out  <= l_hold;
          right_out <= sat[SAMPLE_W-1:0];
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags; a set in the same cycle beats clip_clr.
  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      clip_flag    <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (state == ST_MST && sat[SAMPLE_W]) clip_flag <= 1'b1;
      else if (clip_clr)                    clip_flag <= 1'b0;
      if (busy && sample_strobe)            overrun_flag <= 1'b1;
      else if (clip_clr)                    overrun_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audrey_mixer.sv
// Scoreboard bench for audrey_mixer: model pushes expected L/R, monitor pops on out_valid.
module tb_audrey_mixer;

  logic              clk_audio = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_strobe = 1'b0;
  logic [3:0][15:0]  voice_in = '0;
  logic [3:0][7:0]   voice_vol = '0;
  logic [3:0][3:0]   voice_pan = '0;
  logic [3:0]        voice_mute = '0;
  logic [7:0]        master_vol = '0;
  logic              clip_clr = 1'b0;
  logic [15:0]       left_out, right_out;
  logic              out_valid, busy, clip_flag, overrun_flag;

  audrey_mixer dut (
    .clk_audio(clk_audio), .rst_n(rst_n), .sample_strobe(sample_strobe),
    .voice_in(voice_in), .voice_vol(voice_vol), .voice_pan(voice_pan),
    .voice_mute(voice_mute), .master_vol(master_vol), .clip_clr(clip_clr),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
    .busy(busy), .clip_flag(clip_flag), .overrun_flag(overrun_flag)
  );

  always #5 clk_audio = ~clk_audio;

  typedef struct { int l; int r; int c; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;

  always @(posedge clk_audio) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic exp_t model();
    exp_t e;
    longint al = 0, ar = 0;
    longint s, vv, p, m;
    m = longint'(master_vol);
    for (int i = 0; i < 4; i++) begin
      s  = voice_mute[i] ? 0 : longint'($signed(voice_in[i]));
      vv = longint'(voice_vol[i]);
      p  = (voice_pan[i] > 4'd8) ? 8 : longint'(voice_pan[i]);
      al += s * vv * (8 - p);
      ar += s * vv * p;
    end
    e.l = sat16(((al >>> 11) * m) >>> 8);
    e.r = sat16(((ar >>> 11) * m) >>> 8);
    e.c = cyc + 11;
    return e;
  endfunction

  always @(negedge clk_audio) begin
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("left",    $signed(left_out),  e.l);
        chk("right",   $signed(right_out), e.r);
        chk("latency", cyc - (e.c - 11),   11);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_audio);
  endtask

  task automatic strobe();
    @(negedge clk_audio);
    sample_strobe = 1'b1;
    q.push_back(model());
    @(negedge clk_audio);
    sample_strobe = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    chk("drain", q.size(), 0);
  endtask

  task automatic set_all(input logic [15:0] s, input logic [7:0] vol, input logic [3:0] pan,
                         input logic [3:0] mute, input logic [7:0] mst);
    for (int i = 0; i < 4; i++) begin
      voice_in[i] = s; voice_vol[i] = vol; voice_pan[i] = pan;
    end
    voice_mute = mute; master_vol = mst;
  endtask

  task automatic pulse_clr();
    @(negedge clk_audio); clip_clr = 1'b1;
    @(negedge clk_audio); clip_clr = 1'b0;
  endtask

  initial begin
    // Reset, with a strobe that must lose to it.
    tick(2);
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_left", left_out, 0);
    chk("rst_right", right_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {clip_flag, overrun_flag}, 0);
    rst_n = 1'b1;
    tick(2);

    // Half-pan voice 0.
    set_all(16'd0, 8'd0, 4'd0, 4'b1110, 8'd255);
    voice_in[0] = 16'd16384; voice_vol[0] = 8'd128; voice_pan[0] = 4'd4;
    strobe();
    chk("busy_mix", busy, 1);
    drain();
    chk("clip_none", clip_flag, 0);

    // Positive full scale hard left.
    set_all(16'sd32767, 8'd255, 4'd0, 4'b0000, 8'd255);
    strobe(); drain();
    chk("clip_pos", clip_flag, 1);
    pulse_clr();
    chk("clip_cleared", clip_flag, 0);

    // Negative full scale.
    set_all(16'h8000, 8'd255, 4'd0, 4'b0000, 8'd255);
    strobe(); drain();
    chk("clip_neg", clip_flag, 1);
    pulse_clr();

    // Pan 15 clamps to 8.
    set_all(16'd0, 8'd0, 4'd0, 4'b1110, 8'd255);
    voice_in[0] = 16'd2048; voice_vol[0] = 8'd128; voice_pan[0] = 4'd15;
    strobe(); drain();

    // Master zero, and all muted.
    set_all(16'd12345, 8'd200, 4'd3, 4'b0000, 8'd0);
    strobe(); drain();
    set_all(16'd12345, 8'd200, 4'd3, 4'b1111, 8'd255);
    strobe(); drain();

    // Overrun: second strobe at cycle 5, voice change at cycle 3.
    set_all(16'd1000, 8'd100, 4'd2, 4'b0000, 8'd200);
    strobe();
    tick(2);
    voice_in[1] = 16'd30000;
    tick(2);
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
    drain();
    tick(3);
    chk("overrun_set", overrun_flag, 1);
    pulse_clr();
    chk("overrun_clr", overrun_flag, 0);

    // Reset mid-mix abandons the mix; next strobe is clean.
    set_all(16'd5000, 8'd150, 4'd5, 4'b0000, 8'd255);
    strobe();
    q.delete();
    tick(5);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_left", left_out, 0);
    chk("midrst_right", right_out, 0);
    chk("midrst_busy", busy, 0);
    tick(12);
    strobe(); drain();

    // Random mixes.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        voice_in[i]  = 16'($urandom);
        voice_vol[i] = 8'($urandom);
        voice_pan[i] = 4'($urandom);
      end
      voice_mute = 4'($urandom);
      master_vol = 8'($urandom);
      strobe();
      tick(2);
      voice_in = '0;
      drain();
    end

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
